// File: rtl/medidor_periodo_if.sv
// Sample stream in, period/peak measurement out, for medidor_periodo.
interface medidor_periodo_if #(
  parameter int CNT_W = 16
);
  logic             sample_valid;
  logic [7:0]       sample;
  logic [CNT_W-1:0] periodo;
  logic [7:0]       pico_max;
  logic [7:0]       pico_min;
  logic             medida_valida;
  logic             sin_senal;

  modport master (
    output sample_valid, sample,
    input  periodo, pico_max, pico_min, medida_valida, sin_senal
  );

  modport slave (
    input  sample_valid, sample,
    output periodo, pico_max, pico_min, medida_valida, sin_senal
  );
endinterface

// File: rtl/medidor_periodo.sv
// Period and peak meter for an 8-bit midscale-128 waveform, using hysteretic crossings.
// Results and the medida_valida pulse register one cycle after the closing crossing; sample_valid=0 cycles freeze all state.
module medidor_periodo #(
  parameter int HYST  = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  medidor_periodo_if.slave  bus
);

  localparam logic [7:0]       TL      = 8'(128 - HYST);
  localparam logic [7:0]       TH      = 8'(128 + HYST);
  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LIM = {{(CNT_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    BUSCAR_BAJO,
    BUSCAR_ALTO,
    MEDIR_BAJO,
    MEDIR_ALTO
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       max_q, max_d, min_q, min_d;
  logic [CNT_W-1:0] periodo_q, periodo_d;
  logic [7:0]       pmax_q, pmax_d, pmin_q, pmin_d;
  logic             mv_q, mv_d, ss_q, ss_d;

  logic is_low, is_high, at_lim;
  logic track, restart, timeout;

  assign is_low  = (bus.sample <= TL);
  assign is_high = (bus.sample >= TH);
  assign at_lim  = (cnt_q == CNT_LIM);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    max_d     = max_q;
    min_d     = min_q;
    periodo_d = periodo_q;
    pmax_d    = pmax_q;
    pmin_d    = pmin_q;
    mv_d      = 1'b0;
    ss_d      = ss_q;
    track     = 1'b0;
    restart   = 1'b0;
    timeout   = 1'b0;

    if (bus.sample_valid) begin
      case (state_q)
        BUSCAR_BAJO: if (is_low) state_d = BUSCAR_ALTO;
        BUSCAR_ALTO: if (is_high) restart = 1'b1;
        MEDIR_BAJO: begin
          if (at_lim) begin
            timeout = 1'b1;
          end else begin
            track = 1'b1;
            if (is_low) state_d = MEDIR_ALTO;
          end
        end
        MEDIR_ALTO: begin
          // Closing crossing publishes the trackers as they were before this sample.
          if (is_high) begin
            periodo_d = cnt_q + ONE;
            pmax_d    = max_q;
            pmin_d    = min_q;
            mv_d      = 1'b1;
            ss_d      = 1'b0;
            restart   = 1'b1;
          end else if (at_lim) begin
            timeout = 1'b1;
          end else begin
            track = 1'b1;
          end
        end
        default: state_d = BUSCAR_BAJO;
      endcase
    end

    if (restart) begin
      cnt_d   = '0;
      max_d   = bus.sample;
      min_d   = bus.sample;
      state_d = MEDIR_BAJO;
    end
    if (track) begin
      cnt_d = cnt_q + ONE;
      if (bus.sample > max_q) max_d = bus.sample;
      if (bus.sample < min_q) min_d = bus.sample;
    end
    // Counter saturation: give up on this period rather than wrap.
    if (timeout) begin
      ss_d    = 1'b1;
      cnt_d   = '0;
      state_d = BUSCAR_BAJO;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BUSCAR_BAJO;
      cnt_q     <= '0;
      max_q     <= 8'd0;
      min_q     <= 8'd255;
      periodo_q <= '0;
      pmax_q    <= 8'd0;
      pmin_q    <= 8'd255;
      mv_q      <= 1'b0;
      ss_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      max_q     <= max_d;
      min_q     <= min_d;
      periodo_q <= periodo_d;
      pmax_q    <= pmax_d;
      pmin_q    <= pmin_d;
      mv_q      <= mv_d;
      ss_q      <= ss_d;
    end
  end

  assign bus.periodo       = periodo_q;
  assign bus.pico_max      = pmax_q;
  assign bus.pico_min      = pmin_q;
  assign bus.medida_valida = mv_q;
  assign bus.sin_senal     = ss_q;

endmodule

// File: tb/tb_medidor_periodo.sv
// Bench: two instances (CNT_W=16 and CNT_W=8, HYST=8) fed one stream, each checked every cycle against a sample-list model.
module tb_medidor_periodo;

  localparam int TL = 120;
  localparam int TH = 136;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  medidor_periodo_if #(.CNT_W(16)) a ();
  medidor_periodo_if #(.CNT_W(8))  b ();

  medidor_periodo #(.HYST(8), .CNT_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(a));
  medidor_periodo #(.HYST(8), .CNT_W(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b));

  // Model: n = number of samples since the opening crossing, inclusive.
  typedef struct {
    bit armed;
    bit meas;
    bit low_seen;
    int n;
    int mx;
    int mn;
    int periodo;
    int pmax;
    int pmin;
    bit mv;
    bit ss;
  } mdl_t;

  typedef struct {
    bit v;
    int s;
    int p;
    int mx;
    int mn;
    bit mv;
  } vec_t;

  mdl_t ma, mb;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   widx = 0;
  bit   prev_mv = 0;
  int   pulses[$];

  function automatic mdl_t mreset();
    mdl_t r;
    r.armed = 0; r.meas = 0; r.low_seen = 0; r.n = 0; r.mx = 0; r.mn = 255;
    r.periodo = 0; r.pmax = 0; r.pmin = 255; r.mv = 0; r.ss = 0;
    return r;
  endfunction

  function automatic mdl_t mstep(mdl_t m, bit v, int s, int cw);
    mdl_t r = m;
    r.mv = 0;
    if (v) begin
      if (!r.meas) begin
        if (!r.armed) r.armed = (s <= TL);
        else if (s >= TH) begin
          r.meas = 1; r.low_seen = 0; r.n = 1; r.mx = s; r.mn = s;
        end
      end else if (r.low_seen && s >= TH) begin
        r.periodo = r.n; r.pmax = r.mx; r.pmin = r.mn; r.mv = 1; r.ss = 0;
        r.n = 1; r.mx = s; r.mn = s; r.low_seen = 0;
      end else if (r.n == (1 << cw) - 1) begin
        r.ss = 1; r.meas = 0; r.armed = 0;
      end else begin
        r.n++;
        if (s > r.mx) r.mx = s;
        if (s < r.mn) r.mn = s;
        if (s <= TL) r.low_seen = 1;
      end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic vcheck(input string nm, input int p, input int mx, input int mn,
                        input bit mv, input bit ss, input mdl_t m);
    vectors++;
    if (p != m.periodo || mx != m.pmax || mn != m.pmin || mv != m.mv || ss != m.ss) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got periodo=%0d max=%0d min=%0d mv=%0d ss=%0d, expected periodo=%0d max=%0d min=%0d mv=%0d ss=%0d",
               nm, cyc, p, mx, mn, mv, ss, m.periodo, m.pmax, m.pmin, m.mv, m.ss);
    end
  endtask

  task automatic check_both(input string tag);
    vcheck({tag, "_w16"}, int'(a.periodo), int'(a.pico_max), int'(a.pico_min),
           a.medida_valida, a.sin_senal, ma);
    vcheck({tag, "_w8"}, int'(b.periodo), int'(b.pico_max), int'(b.pico_min),
           b.medida_valida, b.sin_senal, mb);
  endtask

  task automatic step(input bit v, input int s);
    @(negedge clk);
    a.sample_valid = v; a.sample = 8'(s);
    b.sample_valid = v; b.sample = 8'(s);
    ma = mstep(ma, v, s, 16);
    mb = mstep(mb, v, s, 8);
    @(posedge clk);
    #1;
    cyc++;
    check_both("step");
    if (prev_mv) chk("no_double_pulse", int'(a.medida_valida), 0);
    prev_mv = a.medida_valida;
    if (a.medida_valida) pulses.push_back(cyc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    a.sample_valid = 0; b.sample_valid = 0;
    rst_n = 0;
    ma = mreset(); mb = mreset();
    #1;
    check_both("reset");
    @(negedge clk);
    rst_n = 1;
    prev_mv = 0;
  endtask

  task automatic wave(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      int s;
      s = ((widx % 10) < 5) ? 0 : 255;
      widx++;
      if (gaps) step(0, 77);
      step(1, s);
    end
  endtask

  task automatic check_pulses(input string nm, input int count, input int gap);
    chk({nm, "_count"}, pulses.size(), count);
    for (int i = 1; i < pulses.size(); i++)
      chk({nm, "_gap"}, pulses[i] - pulses[i-1], gap);
  endtask

  vec_t tbl[12];

  initial begin
    a.sample_valid = 0; a.sample = 8'd0;
    b.sample_valid = 0; b.sample = 8'd0;
    do_reset();

    // Worked example, with invalid cycles inserted that must not count or cross.
    tbl[0]  = '{1,   0, 0,   0, 255, 0};
    tbl[1]  = '{1, 140, 0,   0, 255, 0};
    tbl[2]  = '{1, 200, 0,   0, 255, 0};
    tbl[3]  = '{0,   0, 0,   0, 255, 0};
    tbl[4]  = '{1, 250, 0,   0, 255, 0};
    tbl[5]  = '{1, 140, 0,   0, 255, 0};
    tbl[6]  = '{1, 100, 0,   0, 255, 0};
    tbl[7]  = '{1,  30, 0,   0, 255, 0};
    tbl[8]  = '{1,   0, 0,   0, 255, 0};
    tbl[9]  = '{0, 200, 0,   0, 255, 0};
    tbl[10] = '{1, 140, 7, 250,   0, 1};
    tbl[11] = '{1, 140, 7, 250,   0, 0};
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, tbl[i].s);
      chk($sformatf("tbl%0d_periodo", i), int'(a.periodo), tbl[i].p);
      chk($sformatf("tbl%0d_max", i), int'(a.pico_max), tbl[i].mx);
      chk($sformatf("tbl%0d_min", i), int'(a.pico_min), tbl[i].mn);
      chk($sformatf("tbl%0d_mv", i), int'(a.medida_valida), int'(tbl[i].mv));
    end

    // Square wave, valid every cycle.
    do_reset(); widx = 0; pulses.delete();
    wave(65, 0);
    check_pulses("sq", 5, 10);
    chk("sq_periodo", int'(a.periodo), 10);
    chk("sq_max", int'(a.pico_max), 255);
    chk("sq_min", int'(a.pico_min), 0);

    // Same wave with idle cycles interleaved.
    do_reset(); widx = 0; pulses.delete();
    wave(65, 1);
    check_pulses("gap", 5, 20);
    chk("gap_periodo", int'(a.periodo), 10);

    // Wobble inside the hysteresis band.
    do_reset(); pulses.delete();
    for (int i = 0; i < 1000; i++) step(1, (i % 2) ? 131 : 125);
    chk("band_pulses", pulses.size(), 0);
    chk("band_periodo", int'(a.periodo), 0);
    chk("band_periodo_w8", int'(b.periodo), 0);

    // Timeout on the narrow counter, then recovery.
    begin
      int nb;
      do_reset(); widx = 0;
      wave(30, 0);
      nb = 0;
      for (int i = 0; i < 200; i++) begin step(1, 128); nb += int'(b.medida_valida); end
      chk("to_not_yet", int'(b.sin_senal), 0);
      for (int i = 0; i < 100; i++) begin step(1, 128); nb += int'(b.medida_valida); end
      chk("to_set", int'(b.sin_senal), 1);
      chk("to_no_pulse", nb, 0);
      chk("to_periodo_kept", int'(b.periodo), 10);
      widx = 0;
      wave(15, 0);
      chk("to_sticky", int'(b.sin_senal), 1);
      wave(1, 0);
      chk("to_resume_pulse", int'(b.medida_valida), 1);
      chk("to_cleared", int'(b.sin_senal), 0);
      chk("to_resume_periodo", int'(b.periodo), 10);
    end

    // Reset mid-period while locked.
    begin
      int k;
      do_reset(); widx = 0;
      wave(37, 0);
      chk("pre_rst_periodo", int'(a.periodo), 10);
      do_reset();
      chk("rst_periodo", int'(a.periodo), 0);
      chk("rst_min", int'(a.pico_min), 255);
      k = 0;
      for (int i = 1; i <= 40 && k == 0; i++) begin
        wave(1, 0);
        if (a.medida_valida) k = i;
      end
      chk("rst_first_pulse", k, 19);
    end

    // Randomised segments against the model.
    do_reset();
    for (int seg = 0; seg < 60; seg++) begin
      int mode;
      mode = $urandom_range(0, 9);
      if (mode < 5) begin
        int hp, lo, hi, n;
        hp = $urandom_range(1, 25);
        lo = $urandom_range(0, TL);
        hi = $urandom_range(TH, 255);
        n  = $urandom_range(20, 150);
        for (int i = 0; i < n; i++) begin
          int s;
          s = ((i / hp) % 2) ? hi : lo;
          if ($urandom_range(0, 9) == 0) s = $urandom_range(0, 255);
          step($urandom_range(0, 3) != 0, s);
        end
      end else if (mode < 7) begin
        for (int i = 0; i < 50; i++) step($urandom_range(0, 3) != 0, $urandom_range(0, 255));
      end else if (mode < 9) begin
        int n;
        n = $urandom_range(100, 320);
        for (int i = 0; i < n; i++) step($urandom_range(0, 7) != 0, $urandom_range(TL + 1, TH - 1));
      end else begin
        do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
